// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types and constants for the SPI memory arbiter slice.
package spi_mem_pkg;
    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester-side and spi_top-side signals of the arbiter; slave = arbiter view.
interface spi_mem_arbiter_if;
    import spi_mem_pkg::*;

    logic              req0_valid, req0_wr, req0_ready, req0_done, req0_error;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_din, req0_dout;
    logic              req1_valid, req1_wr, req1_ready, req1_done, req1_error;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_din, req1_dout;

    logic              spi_req, spi_wr, spi_done, spi_error;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_din, spi_dout;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_din,
        output req0_ready, req0_done, req0_error, req0_dout,
        input  req1_valid, req1_wr, req1_addr, req1_din,
        output req1_ready, req1_done, req1_error, req1_dout,
        output spi_req, spi_wr, spi_addr, spi_din,
        input  spi_done, spi_error, spi_dout
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_din,
        input  req0_ready, req0_done, req0_error, req0_dout,
        output req1_valid, req1_wr, req1_addr, req1_din,
        input  req1_ready, req1_done, req1_error, req1_dout,
        input  spi_req, spi_wr, spi_addr, spi_din,
        output spi_done, spi_error, spi_dout
    );
endinterface

// File: rtl/spi_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant generator; last grant is updated only on upd_i.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);
    logic last_q, last_d;
    logic idx;

    always_comb begin
        idx = 1'b0;
        if (req_i[0] && req_i[1]) begin
            idx = ~last_q;
        end else if (req_i[1]) begin
            idx = 1'b1;
        end
        last_d = upd_i ? idx : last_q;
    end

    assign gnt_idx_o = idx;
    assign gnt_o     = {idx, ~idx} & {2{|req_i}};

    // Reset points at requester 1 so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates two requesters onto a single spi_top operation slot with timeout.
//   state | meaning
//   IDLE  | no operation outstanding, grant on any valid
//   BUSY  | operation presented to spi_top, waiting for spi_done or timeout
//   RESP  | done pulse to the granted requester
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = 11
) (
    input logic              clk,
    input logic              rstn,
    spi_mem_arbiter_if.slave bus
);
    localparam logic [1:0]      IDLE    = ST_IDLE;
    localparam logic [1:0]      BUSY    = ST_BUSY;
    localparam logic [1:0]      RESP    = ST_RESP;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]              state_q, state_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    sel_q, sel_d;
    logic                    wr_q, wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       din_q, din_d;
    logic [1:0][DATA_W-1:0]  dout_q, dout_d;
    logic [1:0]              err_q, err_d;
    logic [1:0]              gnt;
    logic                    gnt_idx;
    logic                    accept;

    spi_rr_arb2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     ({bus.req1_valid, bus.req0_valid}),
        .upd_i     (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        sel_d    = sel_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        din_d    = din_q;
        dout_d   = dout_q;
        err_d    = err_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept   = 1'b1;
                    sel_d    = gnt_idx;
                    wr_d     = gnt_idx ? bus.req1_wr   : bus.req0_wr;
                    addr_d   = gnt_idx ? bus.req1_addr : bus.req0_addr;
                    din_d    = gnt_idx ? bus.req1_din  : bus.req0_din;
                    to_cnt_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // A real completion on the last allowed cycle beats the timeout.
                if (bus.spi_done) begin
                    dout_d[sel_q] = bus.spi_dout;
                    err_d[sel_q]  = bus.spi_error;
                    state_d       = RESP;
                end else if (to_cnt_q == TO_LAST) begin
                    dout_d[sel_q] = '0;
                    err_d[sel_q]  = 1'b1;
                    state_d       = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
        end
    end

    assign bus.req0_ready = rstn & accept & gnt[0];
    assign bus.req1_ready = rstn & accept & gnt[1];
    assign bus.req0_done  = rstn & (state_q == RESP) & ~sel_q;
    assign bus.req1_done  = rstn & (state_q == RESP) & sel_q;
    assign bus.req0_error = err_q[0];
    assign bus.req1_error = err_q[1];
    assign bus.req0_dout  = dout_q[0];
    assign bus.req1_dout  = dout_q[1];
    assign bus.spi_req    = (state_q == BUSY);
    assign bus.spi_wr     = wr_q;
    assign bus.spi_addr   = addr_q;
    assign bus.spi_din    = din_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter; the bench itself plays spi_top with a small memory.
module tb_spi_mem_arbiter;
    import spi_mem_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [7:0] mem [256];

    spi_mem_arbiter_if bus();

    spi_mem_arbiter #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rdy(input int n);
        return (n == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic dn(input int n);
        return (n == 0) ? bus.req0_done : bus.req1_done;
    endfunction

    task automatic set_req(input int n, input logic v, input logic wr,
                           input logic [7:0] a, input logic [7:0] d);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_wr = wr; bus.req0_addr = a; bus.req0_din = d;
        end else begin
            bus.req1_valid = v; bus.req1_wr = wr; bus.req1_addr = a; bus.req1_din = d;
        end
    endtask

    // One operation: spi_done is raised in BUSY cycle dly (dly=0 never raises it).
    task automatic run_op(input int n, input logic wr, input logic [7:0] addr,
                          input logic [7:0] din, input int dly, input logic serr,
                          output int acc, output int req_cyc, output int dcyc,
                          output logic [7:0] dout, output logic err,
                          output logic fields_ok, output logic quiet_ok);
        logic got;
        int   k;
        acc = -1; req_cyc = -1; dcyc = -1; dout = 8'hxx; err = 1'bx;
        fields_ok = 1'b1; quiet_ok = 1'b1; got = 1'b0; k = 1;
        @(negedge clk);
        set_req(n, 1'b1, wr, addr, din);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (rdy(n)) begin
                got = 1'b1;
                acc = cyc;
                if (rdy(1 - n)) quiet_ok = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        set_req(n, 1'b0, ~wr, ~addr, ~din);
        if (!got) return;
        for (int i = 0; i < 64 && dcyc < 0; i++) begin
            #1;
            if (bus.spi_req) begin
                if (req_cyc < 0) req_cyc = cyc;
                if (bus.spi_wr !== wr || bus.spi_addr !== addr || bus.spi_din !== din)
                    fields_ok = 1'b0;
            end
            if (bus.req0_ready || bus.req1_ready || dn(1 - n)) quiet_ok = 1'b0;
            if (dn(n)) begin
                dcyc = cyc;
                dout = (n == 0) ? bus.req0_dout : bus.req1_dout;
                err  = (n == 0) ? bus.req0_error : bus.req1_error;
            end else begin
                if (bus.spi_req && k == dly) begin
                    bus.spi_done  = 1'b1;
                    bus.spi_error = serr;
                    bus.spi_dout  = mem[bus.spi_addr];
                    if (bus.spi_wr) mem[bus.spi_addr] = bus.spi_din;
                end
                if (bus.spi_req) k++;
                @(negedge clk);
                bus.spi_done  = 1'b0;
                bus.spi_error = 1'b0;
                bus.spi_dout  = 8'h5A;
            end
        end
        @(negedge clk);
        #1;
        if (dn(n)) quiet_ok = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready);
        end
        checks++;
        if ({bus.spi_req, bus.spi_wr, bus.req1_ready, bus.req0_done, bus.req1_done,
             bus.req0_error, bus.req1_error} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000000", {bus.spi_req, bus.spi_wr,
                     bus.req1_ready, bus.req0_done, bus.req1_done, bus.req0_error, bus.req1_error});
        end
        checks++;
        if ({bus.spi_addr, bus.spi_din, bus.req0_dout, bus.req1_dout} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00000000",
                     {bus.spi_addr, bus.spi_din, bus.req0_dout, bus.req1_dout});
        end
        bus.req0_valid = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_single_write();
        int acc, rc, dc; logic [7:0] d; logic e, fo, qo;
        run_op(0, 1'b1, 8'h10, 8'hA5, 2, 1'b0, acc, rc, dc, d, e, fo, qo);
        checks++;
        if (acc < 0) begin failures++; $display("FAIL wr_ready0 got=none exp=pulse"); end
        checks++;
        if (rc !== acc + 1) begin
            failures++; $display("FAIL wr_spi_req_rise got=%0d exp=%0d", rc, acc + 1);
        end
        checks++;
        if (fo !== 1'b1) begin failures++; $display("FAIL wr_spi_fields got=%b exp=1", fo); end
        checks++;
        if (dc - acc !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", dc - acc); end
        checks++;
        if (e !== 1'b0) begin failures++; $display("FAIL wr_error0 got=%b exp=0", e); end
        checks++;
        if (qo !== 1'b1) begin failures++; $display("FAIL wr_quiet got=%b exp=1", qo); end
    endtask

    task automatic test_read_back();
        int acc, rc, dc; logic [7:0] d; logic e, fo, qo; logic stray;
        run_op(1, 1'b0, 8'h10, 8'h00, 1, 1'b0, acc, rc, dc, d, e, fo, qo);
        checks++;
        if (d !== 8'hA5) begin failures++; $display("FAIL rd_dout1 got=%h exp=a5", d); end
        checks++;
        if (e !== 1'b0 || dc - acc !== 2) begin
            failures++; $display("FAIL rd_err_lat got=%b/%0d exp=0/2", e, dc - acc);
        end
        checks++;
        if (qo !== 1'b1 || fo !== 1'b1) begin
            failures++; $display("FAIL rd_quiet_fields got=%b%b exp=11", qo, fo);
        end
        // spi_done / spi_error while idle must be ignored; captured values held.
        @(negedge clk);
        bus.spi_done = 1'b1; bus.spi_error = 1'b1; bus.spi_dout = 8'h77;
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.spi_done = 1'b0; bus.spi_error = 1'b0; bus.spi_dout = 8'h5A;
            #1;
            if (bus.req0_done || bus.req1_done || bus.spi_req) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin failures++; $display("FAIL idle_spi_done got=stray exp=none"); end
        checks++;
        if (bus.req1_dout !== 8'hA5 || bus.req1_error !== 1'b0) begin
            failures++;
            $display("FAIL hold_dout1 got=%h/%b exp=a5/0", bus.req1_dout, bus.req1_error);
        end
    endtask

    task automatic test_back_to_back();
        int order[4]; int accs[4]; int dord[4];
        int ng, nd, viol;
        logic [7:0] exp_order;
        ng = 0; nd = 0; viol = 0;
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h20, 8'h01);
        set_req(1, 1'b1, 1'b1, 8'h21, 8'h02);
        for (int i = 0; i < 30; i++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) viol++;
            if ((bus.req0_ready || bus.req1_ready) && bus.spi_req) viol++;
            if (ng < 4 && (bus.req0_ready || bus.req1_ready)) begin
                order[ng] = bus.req1_ready ? 1 : 0;
                accs[ng]  = cyc;
                ng++;
            end
            if (bus.req0_done || bus.req1_done) begin
                if (nd < 4) dord[nd] = bus.req1_done ? 1 : 0;
                nd++;
            end
            bus.spi_done = bus.spi_req;
            @(negedge clk);
            if (ng >= 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
        end
        bus.spi_done = 1'b0;
        exp_order = 8'b01_00_01_00;
        checks++;
        if (ng != 4 || {2'(order[3]), 2'(order[2]), 2'(order[1]), 2'(order[0])} !== exp_order) begin
            failures++;
            $display("FAIL b2b_grant_order got=%0d%0d%0d%0d (n=%0d) exp=0101",
                     order[0], order[1], order[2], order[3], ng);
        end
        checks++;
        if (nd != 4 || {2'(dord[3]), 2'(dord[2]), 2'(dord[1]), 2'(dord[0])} !== exp_order) begin
            failures++; $display("FAIL b2b_done_order got=%0d dones exp=4 in order 0101", nd);
        end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL b2b_outstanding got=%0d exp=0", viol); end
        checks++;
        if (ng == 4 && (accs[1] - accs[0] != 3 || accs[2] - accs[1] != 3 || accs[3] - accs[2] != 3)) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=3,3,3",
                     accs[1] - accs[0], accs[2] - accs[1], accs[3] - accs[2]);
        end
    endtask

    task automatic test_timeout();
        int acc, rc, dc; logic [7:0] d; logic e, fo, qo;
        run_op(0, 1'b0, 8'h33, 8'h00, 0, 1'b0, acc, rc, dc, d, e, fo, qo);
        checks++;
        if (dc - rc !== 16) begin
            failures++; $display("FAIL to_busy_cycles got=%0d exp=16", dc - rc);
        end
        checks++;
        if (e !== 1'b1 || d !== 8'h00) begin
            failures++; $display("FAIL to_status got=%b/%h exp=1/00", e, d);
        end
        checks++;
        if (qo !== 1'b1) begin failures++; $display("FAIL to_quiet got=%b exp=1", qo); end
    endtask

    task automatic test_error();
        int acc, rc, dc; logic [7:0] d; logic e, fo, qo;
        run_op(1, 1'b0, 8'hFF, 8'h00, 3, 1'b1, acc, rc, dc, d, e, fo, qo);
        checks++;
        if (e !== 1'b1 || dc - acc !== 4) begin
            failures++; $display("FAIL err_flag got=%b/%0d exp=1/4", e, dc - acc);
        end
    endtask

    task automatic test_done_at_timeout();
        int acc, rc, dc; logic [7:0] d; logic e, fo, qo;
        run_op(0, 1'b0, 8'h10, 8'h00, 16, 1'b0, acc, rc, dc, d, e, fo, qo);
        checks++;
        if (dc - acc !== 17 || e !== 1'b0 || d !== 8'hA5) begin
            failures++;
            $display("FAIL done_vs_timeout got=%0d/%b/%h exp=17/0/a5", dc - acc, e, d);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic got, stray;
        got = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 8'h40, 8'h99);
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (bus.req0_ready) got = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (!got || bus.spi_req !== 1'b1) begin
            failures++; $display("FAIL mid_busy_pre got=%b%b exp=11", got, bus.spi_req);
        end
        rstn = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.spi_req, bus.spi_wr, bus.req0_ready, bus.req1_ready, bus.req0_done,
             bus.req1_done, bus.req0_error, bus.req1_error} !== 8'b0 ||
            {bus.spi_addr, bus.spi_din, bus.req0_dout, bus.req1_dout} !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b/%h exp=0/00000000",
                     {bus.spi_req, bus.spi_wr, bus.req0_done, bus.req1_done, bus.req0_error, bus.req1_error},
                     {bus.spi_addr, bus.spi_din, bus.req0_dout, bus.req1_dout});
        end
        rstn = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.req0_done || bus.req1_done || bus.spi_req) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin failures++; $display("FAIL mid_no_done got=stray exp=none"); end
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rstn = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        bus.spi_done  = 1'b0;
        bus.spi_error = 1'b0;
        bus.spi_dout  = 8'h5A;
        test_reset();
        test_single_write();
        test_read_back();
        test_back_to_back();
        test_timeout();
        test_error();
        test_done_at_timeout();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 1024, max cycles waited for spi_done before abort.
REQ-002 Parameter: TO_W, default 11, timeout counter width; SHALL hold TIMEOUT_CYC.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 reqN_valid  input  1  requester N (N=0,1) operation request, held until accepted.
REQ-006 reqN_wr  input  1  1 = write, 0 = read.
REQ-007 reqN_addr  input  8  memory address.
REQ-008 reqN_din  input  8  write data.
REQ-009 reqN_ready  output  1  one-cycle accept pulse.
REQ-010 reqN_done  output  1  one-cycle completion pulse.
REQ-011 reqN_error  output  1  error qualifier, valid with reqN_done.
REQ-012 reqN_dout  output  8  read data, valid with reqN_done.
REQ-013 spi_req  output  1  operation active toward spi_top; level.
REQ-014 spi_wr, spi_addr[7:0], spi_din[7:0]  output  operation fields to spi_top wr/addr/din.
REQ-015 spi_done, spi_error  input  1  completion/error from spi_top.
REQ-016 spi_dout  input  8  read data from spi_top.

Function
REQ-017 States: IDLE, BUSY, RESP; exactly one operation outstanding toward spi_top at any time.
REQ-018 IDLE, any reqN_valid=1 -> grant one requester, pulse its reqN_ready in that cycle, latch wr/addr/din, next state BUSY.
REQ-019 Arbitration: round-robin. On simultaneous valids, grant the requester not granted last. After reset, requester 0 has priority.
REQ-020 BUSY: spi_req=1; spi_wr/addr/din SHALL equal the latched fields and stay stable until exit.
REQ-021 spi_req SHALL be 1 exactly in BUSY; it rises the cycle after accept.
REQ-022 BUSY, spi_done=1 -> capture spi_dout and spi_error, next state RESP.
REQ-023 BUSY timeout: a counter clears on entry and increments each BUSY cycle. If it reaches TIMEOUT_CYC-1 with spi_done=0, next state is RESP with error=1 and dout=8'h00.
REQ-024 spi_done in the same cycle as the timeout: spi_done wins and the real status is captured.
REQ-025 RESP: pulse the granted reqN_done for one cycle with captured reqN_dout and reqN_error. Next state IDLE; no new grant in RESP.
REQ-026 Minimum latency: accept cycle T, spi_req high from T+1, spi_done at T+k gives reqN_done at T+k+1.
REQ-027 Throughput: a new accept is possible at the earliest 1 cycle after RESP, in IDLE.
REQ-028 reqN_dout and reqN_error SHALL hold their last captured values between done pulses.
REQ-029 Non-granted requester outputs: ready=0 and done=0.
REQ-030 spi_done/spi_error outside BUSY SHALL be ignored.
REQ-031 Requester input changes after accept SHALL NOT affect the outstanding operation.

Reset
REQ-032 rstn=0 at a clock edge: state IDLE; last-grant points to requester 1, so requester 0 wins next.
REQ-033 During reset: timeout counter 0; spi_req, spi_wr, all ready, all done and all error 0; spi_addr, spi_din and all dout 8'h00.
REQ-034 Reset mid-operation (BUSY or RESP) SHALL abort without emitting reqN_done; spi_req drops the cycle after the reset edge.

Structure
REQ-035 Shared package spi_mem_pkg holds the state enum (IDLE/BUSY/RESP), ADDR_W=8, DATA_W=8 and the default timeout constant.
REQ-036 One sub-module, spi_rr_arb2: a 2-input round-robin grant generator with last-grant register and update enable.
REQ-037 The block instantiates spi_top unmodified downstream, or connects to it externally; no change to spi_top ports.

Verification
REQ-038 Single write: req0 wr=1, addr=8'h10, din=8'hA5 -> ready0 pulse; spi_req high with 8'h10/8'hA5; done0 one cycle after spi_done, error0=0.
REQ-039 Read-back: req1 read addr=8'h10 after REQ-038 -> done1 with dout1=8'hA5.
REQ-040 Simultaneous valids from reset -> grant order 0,1,0,1 over four back-to-back ops; never two outstanding.
REQ-041 Timeout: TIMEOUT_CYC=16 with spi_done held 0 -> done pulse exactly 16 BUSY cycles after entry, error=1, dout=8'h00.
REQ-042 Error path: read addr=8'hFF with spi_error=1 on spi_done -> reqN_error=1 with the done pulse.
REQ-043 Reset asserted 3 cycles into BUSY -> no done pulse; all outputs at reset values; requester 0 is granted first afterward.
